// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl
//   Request-side controller in front of a single-port synchronous RAM with
//   registered read. Takes read/write requests on a valid/ready channel,
//   sequences RAM chip-select, write-enable, address and the shared data bus,
//   returns read data on a valid/ready response channel and keeps saturating
//   read/write transaction counters.
//
// Ports
//   clk_i, rst_i             clock (rising edge), asynchronous active-high reset
//   req_valid_i/req_ready_o  request handshake; ready only while idle
//   req_we_i, req_addr_i,    request kind (1 = write), address, write data
//   req_wdata_i
//   rsp_valid_o/rsp_ready_i  read response handshake
//   rsp_rdata_o              read data, stable while rsp_valid_o is high
//   wr_done_o                one-cycle pulse after a write reached the RAM
//   busy_o                   controller not idle
//   ram_cs_o, ram_we_o,      RAM control/address (all registered)
//   ram_addr_o
//   ram_data_io              RAM data bus, driven here only during a write
//   wr_count_o, rd_count_o   committed writes / delivered read responses,
//                            saturating at all-ones
module ram_req_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int TURN_CYC = 1   // idle cycles after each write, 0..7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              wr_done_o,
  output logic              busy_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  inout  wire  [DATA_W-1:0] ram_data_io,
  output logic [CNT_W-1:0]  wr_count_o,
  output logic [CNT_W-1:0]  rd_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_TURN,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP_WAIT
  } state_t;

  // TURN is entered with TURN_CYC-1 and left when the counter reads zero,
  // so exactly TURN_CYC cycles are spent there.
  localparam logic [2:0] TURN_LOAD = (TURN_CYC > 0) ? 3'(TURN_CYC - 1) : 3'd0;

  state_t            state_q,     state_d;
  logic              ram_cs_q,    ram_cs_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [2:0]        turn_cnt_q,  turn_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              wr_done_q,   wr_done_d;
  logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q,    rd_cnt_d;

  // RAM strobes are registered, so they are computed from the state being
  // entered: the access cycle then lines up exactly with that state.
  always_comb begin
    state_d     = state_q;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    wdata_d     = wdata_q;
    turn_cnt_d  = turn_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_done_d   = 1'b0;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          ram_cs_d   = 1'b1;
          ram_addr_d = req_addr_i;
          if (req_we_i) begin
            state_d  = S_WRITE;
            ram_we_d = 1'b1;
            wdata_d  = req_wdata_i;
          end else begin
            state_d  = S_RD_ADDR;
          end
        end
      end

      S_WRITE: begin
        // RAM commits at the edge closing this state.
        wr_done_d = 1'b1;
        if (!(&wr_cnt_q)) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        if (TURN_CYC > 0) begin
          state_d    = S_TURN;
          turn_cnt_d = TURN_LOAD;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_TURN: begin
        if (turn_cnt_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q - 3'd1;
        end
      end

      S_RD_ADDR: begin
        // Keep the RAM selected for the data phase; it drives the bus then.
        ram_cs_d = 1'b1;
        state_d  = S_RD_DATA;
      end

      S_RD_DATA: begin
        rsp_rdata_d = ram_data_io;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP_WAIT;
      end

      S_RSP_WAIT: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (!(&rd_cnt_q)) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      wdata_q     <= '0;
      turn_cnt_q  <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_done_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      wdata_q     <= wdata_d;
      turn_cnt_q  <= turn_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_done_q   <= wr_done_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  // Bus is released whenever this block is not writing, so the RAM can
  // drive it during reads without contention.
  assign ram_data_io = (ram_cs_q && ram_we_q) ? wdata_q : {DATA_W{1'bz}};

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign ram_cs_o    = ram_cs_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wr_done_o   = wr_done_q;
  assign wr_count_o  = wr_cnt_q;
  assign rd_count_o  = rd_cnt_q;

endmodule
